// File: rtl/mem_stage_lat.sv
// MEM pipeline stage: byte-lane data memory with configurable access latency and MEM/WB registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_lat #(
    parameter int DW          = 32,
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mem_r_en,
    input  logic          mem_w_en,
    input  logic [1:0]    mem_size,
    input  logic          load_unsigned,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] st_value,
    input  logic [4:0]    dest_in,
    input  logic          wb_en_in,
    output logic          stall,
    output logic [DW-1:0] fwd_value,
    output logic          wb_valid,
    output logic          wb_en_out,
    output logic [4:0]    dest_out,
    output logic [DW-1:0] alu_res_out,
    output logic [DW-1:0] read_data,
    output logic          mem_r_en_out,
    output logic          misalign
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          wb_valid_q, wb_valid_d;
    logic          wb_en_q, wb_en_d;
    logic [4:0]    dest_q, dest_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          mre_q, mre_d;
    logic          mis_q, mis_d;

    logic          mem_op, last, complete;
    logic          is_byte, is_half, is_word;
    logic          mis_raw, mis;
    logic [AW-1:0] word_idx;
    logic [OW-1:0] offset, off_eff;
    logic [NB-1:0] be;
    logic [DW-1:0] wdata, rword, shifted, ld;
    logic          do_write, do_read;

    logic [DW-1:0] mem [DEPTH];

    assign mem_op   = in_valid & (mem_r_en | mem_w_en);
    assign last     = (cnt_q == CNT_LAST);
    assign stall    = mem_op & ~last;
    assign complete = in_valid & (~mem_op | last);

    assign fwd_value = alu_result;
    assign word_idx  = alu_result[AW+OW-1:OW];
    assign offset    = alu_result[OW-1:0];

    assign is_byte = (mem_size == 2'b00);
    assign is_half = (mem_size == 2'b01);
    assign is_word = mem_size[1];

    assign mis_raw = (is_half & offset[0]) | (is_word & (offset != '0));
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = mem_op & mis_raw;
`else
    assign mis = 1'b0 & mis_raw;
`endif

    // Without the trap, misaligned addresses simply round down to the access size.
    always_comb begin
        off_eff = offset;
        if (is_half) off_eff[0] = 1'b0;
        if (is_word) off_eff = '0;
    end

    always_comb begin
        be    = '0;
        wdata = st_value;
        if (is_word) begin
            be    = '1;
            wdata = st_value;
        end else if (is_half) begin
            be    = NB'(3) << off_eff;
            wdata = {(NB/2){st_value[15:0]}};
        end else if (is_byte) begin
            be    = NB'(1) << off_eff;
            wdata = {NB{st_value[7:0]}};
        end
    end

    assign do_write = complete & mem_op & mem_w_en & ~mem_r_en & ~mis;
    assign do_read  = complete & mem_op & mem_r_en;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rword   = mem[word_idx];
    assign shifted = rword >> {off_eff, 3'b000};

    always_comb begin
        ld = rword;
        if (is_byte) begin
            ld = load_unsigned ? DW'(shifted[7:0]) : {{(DW-8){shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            ld = load_unsigned ? DW'(shifted[15:0]) : {{(DW-16){shifted[15]}}, shifted[15:0]};
        end
        if (mis) ld = '0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        dest_d     = dest_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        mre_d      = mre_q;
        mis_d      = mis_q;

        case (state_q)
            IDLE: begin
                if (mem_op && (MEM_LATENCY > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                // Dropping in_valid mid-access aborts without touching memory.
                if (!in_valid || complete) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (complete) begin
            wb_valid_d = 1'b1;
            wb_en_d    = wb_en_in & ~mis;
            dest_d     = dest_in;
            alu_d      = alu_result;
            mre_d      = mem_r_en;
            mis_d      = mis;
            if (do_read) rd_d = ld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            dest_q     <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            mre_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            dest_q     <= dest_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            mre_q      <= mre_d;
            mis_q      <= mis_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_en_out    = wb_en_q;
    assign dest_out     = dest_q;
    assign alu_res_out  = alu_q;
    assign read_data    = rd_q;
    assign mem_r_en_out = mre_q;
    assign misalign     = mis_q;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Bench for mem_stage_lat: one instance at latency 1, one at latency 3, against a byte-array memory model.
module tb_mem_stage_lat;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       in_valid, mem_r_en, mem_w_en, load_unsigned, wb_en_in;
    logic [1:0][1:0]  mem_size;
    logic [1:0][31:0] alu_result, st_value;
    logic [1:0][4:0]  dest_in;
    logic [1:0]       stall, wb_valid, wb_en_out, mem_r_en_out, misalign;
    logic [1:0][31:0] fwd_value, alu_res_out, read_data;
    logic [1:0][4:0]  dest_out;

    mem_stage_lat #(.DW(32), .DEPTH(256), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .mem_r_en(mem_r_en[0]),
        .mem_w_en(mem_w_en[0]), .mem_size(mem_size[0]), .load_unsigned(load_unsigned[0]),
        .alu_result(alu_result[0]), .st_value(st_value[0]), .dest_in(dest_in[0]),
        .wb_en_in(wb_en_in[0]), .stall(stall[0]), .fwd_value(fwd_value[0]),
        .wb_valid(wb_valid[0]), .wb_en_out(wb_en_out[0]), .dest_out(dest_out[0]),
        .alu_res_out(alu_res_out[0]), .read_data(read_data[0]),
        .mem_r_en_out(mem_r_en_out[0]), .misalign(misalign[0]));

    mem_stage_lat #(.DW(32), .DEPTH(256), .MEM_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .mem_r_en(mem_r_en[1]),
        .mem_w_en(mem_w_en[1]), .mem_size(mem_size[1]), .load_unsigned(load_unsigned[1]),
        .alu_result(alu_result[1]), .st_value(st_value[1]), .dest_in(dest_in[1]),
        .wb_en_in(wb_en_in[1]), .stall(stall[1]), .fwd_value(fwd_value[1]),
        .wb_valid(wb_valid[1]), .wb_en_out(wb_en_out[1]), .dest_out(dest_out[1]),
        .alu_res_out(alu_res_out[1]), .read_data(read_data[1]),
        .mem_r_en_out(mem_r_en_out[1]), .misalign(misalign[1]));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mb [2][1024];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_alu [2];
    logic [4:0]  exp_dest [2];
    logic        exp_mre [2];
    logic        exp_mis [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: 1 KiB wraps, little-endian assembly, arithmetic sign extension.
    function automatic void model_access(input int d, input bit rd, input bit wr,
                                         input logic [1:0] sz, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] st,
                                         output bit mis, output logic [31:0] ld);
        int n;
        int a;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = int'(addr % 1024);
        mis = 1'b0;
        ld  = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (a % n) != 0;
`else
        a = a - (a % n);
`endif
        if (mis) return;
        if (rd) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mb[d][a+k]) << (8*k));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            ld = v;
        end else if (wr) begin
            for (int k = 0; k < n; k++) mb[d][a+k] = st[8*k +: 8];
        end
    endfunction

    task automatic clear_expect();
        for (int d = 0; d < 2; d++) begin
            exp_rd[d] = 32'h0; exp_alu[d] = 32'h0; exp_dest[d] = 5'h0;
            exp_mre[d] = 1'b0; exp_mis[d] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_wb_valid", wb_valid[d], 0);
        check("rst_wb_en", wb_en_out[d], 0);
        check("rst_dest", dest_out[d], 0);
        check("rst_alu", alu_res_out[d], 0);
        check("rst_rdata", read_data[d], 0);
        check("rst_mre", mem_r_en_out[d], 0);
        check("rst_mis", misalign[d], 0);
    endtask

    task automatic run_op(input int d, input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] st,
                          input logic [4:0] dst, input bit wben);
        int lat;
        int stalls;
        bit memop;
        bit mis;
        logic [31:0] ld;
        lat    = (d == 0) ? 1 : 3;
        stalls = 0;
        memop  = rd | wr;
        mis    = 1'b0;
        ld     = 32'h0;
        @(negedge clk);
        in_valid[d] = 1'b1; mem_r_en[d] = rd; mem_w_en[d] = wr; mem_size[d] = sz;
        load_unsigned[d] = uns; alu_result[d] = addr; st_value[d] = st;
        dest_in[d] = dst; wb_en_in[d] = wben;
        #1;
        check("fwd_value", fwd_value[d], addr);
        while (stall[d] && stalls < 10) begin
            stalls++;
            @(negedge clk);
            check("wb_valid_in_stall", wb_valid[d], 0);
        end
        check("stall_cycles", stalls, memop ? lat - 1 : 0);
        if (memop) model_access(d, rd, wr, sz, uns, addr, st, mis, ld);
        exp_dest[d] = dst; exp_alu[d] = addr; exp_mre[d] = rd; exp_mis[d] = mis;
        if (rd) exp_rd[d] = ld;
        @(posedge clk);
        #1;
        check("wb_valid", wb_valid[d], 1);
        check("wb_en_out", wb_en_out[d], wben & ~mis);
        check("dest_out", dest_out[d], exp_dest[d]);
        check("alu_res_out", alu_res_out[d], exp_alu[d]);
        check("mem_r_en_out", mem_r_en_out[d], exp_mre[d]);
        check("read_data", read_data[d], exp_rd[d]);
        check("misalign", misalign[d], exp_mis[d]);
    endtask

    task automatic bubble(input int d);
        @(negedge clk);
        in_valid[d] = 1'b0;
        @(posedge clk);
        #1;
        check("bub_wb_valid", wb_valid[d], 0);
        check("bub_wb_en", wb_en_out[d], 0);
        check("bub_dest_hold", dest_out[d], exp_dest[d]);
        check("bub_rdata_hold", read_data[d], exp_rd[d]);
    endtask

    task automatic init_mem(input int d);
        for (int w = 0; w < 16; w++) run_op(d, 0, 1, 2'd2, 0, 32'(w*4), $urandom, 5'd0, 0);
    endtask

    task automatic random_ops(input int d, input int count);
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 7) == 0) bubble(d);
            run_op(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)),
                   $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0; mem_r_en = '0; mem_w_en = '0; load_unsigned = '0; wb_en_in = '0;
        mem_size = '0; alu_result = '0; st_value = '0; dest_in = '0;
        clear_expect();
        #2;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk);
        rst = 1'b0;

        // Latency 1 instance
        init_mem(0);
        run_op(0, 0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0);
        run_op(0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd5, 1);
        check("tp_lw_data", read_data[0], 32'hDEAD_BEEF);
        run_op(0, 0, 1, 2'd0, 0, 32'h21, 32'h0000_0080, 5'd0, 0);
        run_op(0, 1, 0, 2'd0, 0, 32'h21, 32'h0, 5'd6, 1);
        check("tp_lb_signed", read_data[0], 32'hFFFF_FF80);
        run_op(0, 1, 0, 2'd0, 1, 32'h21, 32'h0, 5'd6, 1);
        check("tp_lbu", read_data[0], 32'h0000_0080);
        run_op(0, 1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd8, 1);
        run_op(0, 0, 1, 2'd2, 0, 32'h400, 32'hCAFE_F00D, 5'd0, 0);
        run_op(0, 1, 0, 2'd2, 0, 32'h0, 32'h0, 5'd9, 1);
        check("tp_wrap", read_data[0], 32'hCAFE_F00D);
        run_op(0, 1, 0, 2'd2, 0, 32'h13, 32'h0, 5'd7, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        check("tp_mis_flag", misalign[0], 1);
        check("tp_mis_rdata", read_data[0], 32'h0);
`else
        check("tp_round_down", read_data[0], 32'hDEAD_BEEF);
`endif
        run_op(0, 0, 1, 2'd1, 0, 32'h13, 32'h0000_5555, 5'd0, 0);
        run_op(0, 1, 1, 2'd2, 0, 32'h10, 32'h1111_1111, 5'd3, 1);
        run_op(0, 1, 0, 2'd1, 0, 32'h12, 32'h0, 5'd4, 1);
        random_ops(0, 60);
        bubble(0);

        // Latency 3 instance
        init_mem(1);
        run_op(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd5, 1);
        run_op(1, 0, 0, 2'd0, 0, 32'h7, 32'h0, 5'd2, 1);
        check("tp_add_alu", alu_res_out[1], 32'h7);

        // Reset during an in-flight store cancels it
        @(negedge clk);
        in_valid[1] = 1'b1; mem_r_en[1] = 1'b0; mem_w_en[1] = 1'b1; mem_size[1] = 2'd2;
        alu_result[1] = 32'h30; st_value[1] = 32'h1234_5678; dest_in[1] = 5'd0; wb_en_in[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs(1);
        check_reset_outputs(0);
        in_valid[1] = 1'b0;
        clear_expect();
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 1, 0, 2'd2, 0, 32'h30, 32'h0, 5'd11, 1);

        random_ops(1, 60);
        bubble(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
